// File: rtl/apb_requester.sv
// apb_requester: single-outstanding APB initiator with wait states and a programmable timeout
//   PCLK, PRESETn                                   clock, synchronous active-low reset
//   cmd_valid/cmd_ready, cmd_write/addr/wdata       CPU-side command handshake
//   rsp_valid, rsp_rdata, rsp_err                   one-cycle completion pulse and held result
//   busy                                            transfer in progress
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA            APB request outputs
//   PRDATA, PREADY                                  APB responder inputs
module apb_requester #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 8
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   // abort fires on the stalled edge that would bring the counter to TIMEOUT
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
   state_t state, nxt;
   logic [TO_W-1:0] wait_cnt;
   logic done, abort;
   always_comb begin
      nxt   = state;
      done  = 1'b0;
      abort = 1'b0;
      case (state)
         IDLE:   nxt = cmd_valid ? SETUP : IDLE;
         SETUP:  nxt = ACCESS;
         ACCESS: begin
            done  = PREADY;
            abort = !PREADY && (TIMEOUT != 0) && (wait_cnt == TO_LAST);
            nxt   = (done || abort) ? IDLE : ACCESS;
         end
         default: nxt = IDLE;
      endcase
   end
   // all outputs are registered from the next state so they change only on PCLK
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         state     <= nxt;
         cmd_ready <= nxt == IDLE;
         busy      <= nxt != IDLE;
         PSEL      <= nxt != IDLE;
         PENABLE   <= nxt == ACCESS;
         rsp_valid <= done || abort;
         if (done || abort) begin
            rsp_err   <= abort;
            rsp_rdata <= (done && !PWRITE) ? PRDATA : '0;
         end
         if (state == IDLE && cmd_valid) begin
            PWRITE   <= cmd_write;
            PADDR    <= cmd_addr;
            wait_cnt <= '0;
            if (cmd_write) PWDATA <= cmd_wdata;
         end else if (state == ACCESS && !PREADY && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: scoreboard bench for apb_requester against a small APB register-file model
module tb_apb_requester;
   localparam int TO = 4;
   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [7:0] cmd_addr = '0, cmd_wdata = '0;
   logic       rsp_valid, rsp_err, busy;
   logic [7:0] rsp_rdata;
   logic       PSEL, PENABLE, PWRITE, PREADY;
   logic [7:0] PADDR, PWDATA, PRDATA;
   apb_requester #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO), .TO_W(8)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY)
   );
   always #5 PCLK = ~PCLK;
   int tests = 0, fails = 0, cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // responder model: register file, PREADY held low for 'waits' ACCESS cycles or forever when hang
   logic [7:0] mem [16];
   logic       mem_init = 1'b0, hang = 1'b0;
   int         waits = 0, acc_cnt = 0;
   assign PREADY = !hang && acc_cnt >= waits;
   assign PRDATA = mem[PADDR[3:0]];
   always @(posedge PCLK) begin
      acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
      if (!PRESETn && !mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'(i);
         mem[2]   <= 8'hCC;
         mem_init <= 1'b1;
      end else if (PSEL && PENABLE && PREADY && PWRITE) begin
         mem[PADDR[3:0]] <= PWDATA;
      end
   end
   typedef struct {logic err; logic [7:0] rdata; int due;} exp_t;
   exp_t q[$];
   exp_t e;
   always @(negedge PCLK) begin
      if (rsp_valid === 1'b1) begin
         if (q.size() == 0) chk("rsp_unexpected", 1, 0);
         else begin
            e = q.pop_front();
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_cycle", cyc, e.due);
         end
      end
   end
   logic [7:0] exp_paddr = '0, exp_pwdata = '0;
   logic       exp_pwrite = 1'b0;
   always @(negedge PCLK) begin
      if (PSEL === 1'b1) begin
         chk("paddr_stable", PADDR, exp_paddr);
         chk("pwrite_stable", PWRITE, exp_pwrite);
         chk("pwdata_stable", PWDATA, exp_pwdata);
      end
   end
   // present a command, wait (bounded) for acceptance, return at the negedge of the SETUP cycle
   task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d, input int nw,
                        input logic h, input logic push, input logic [7:0] e_rd, output int acc);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge PCLK);
         n++;
      end
      acc = cyc + 1;
      if (cmd_ready !== 1'b1) begin
         chk("accept_bound", 0, 1);
         return;
      end
      waits = nw; hang = h;
      exp_paddr = a; exp_pwrite = w;
      if (w) exp_pwdata = d;
      if (push) q.push_back('{h, e_rd, h ? acc + 1 + TO : acc + 2 + nw});
      @(posedge PCLK);
      @(negedge PCLK);
   endtask
   task automatic write0_phases();
      int a;
      issue(1'b1, 8'h00, 8'hAA, 0, 1'b0, 1'b1, 8'h00, a);
      cmd_valid = 1'b0;
      chk("setup_psel", PSEL, 1); chk("setup_penable", PENABLE, 0);
      chk("setup_cmd_ready", cmd_ready, 0); chk("setup_busy", busy, 1);
      chk("setup_pwrite", PWRITE, 1); chk("setup_paddr", PADDR, 8'h00); chk("setup_pwdata", PWDATA, 8'hAA);
      @(negedge PCLK);
      chk("access_psel", PSEL, 1); chk("access_penable", PENABLE, 1);
      @(negedge PCLK);
      chk("done_psel", PSEL, 0); chk("done_penable", PENABLE, 0);
      chk("done_cmd_ready", cmd_ready, 1); chk("done_rsp_valid", rsp_valid, 1);
   endtask
   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_psel"}, PSEL, 0); chk({tag, "_penable"}, PENABLE, 0);
      chk({tag, "_pwrite"}, PWRITE, 0); chk({tag, "_paddr"}, PADDR, 0);
      chk({tag, "_pwdata"}, PWDATA, 0); chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 0); chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask
   logic [7:0] vals [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
   int acc [4];
   int a, b;
   initial begin
      repeat (3) @(negedge PCLK);
      chk_reset_outputs("reset");
      PRESETn = 1'b1;
      @(negedge PCLK);
      chk("release_cmd_ready", cmd_ready, 1);
      write0_phases();
      // read with two wait states
      issue(1'b0, 8'h02, 8'h00, 2, 1'b0, 1'b1, 8'hCC, a);
      cmd_valid = 1'b0;
      repeat (6) @(negedge PCLK);
      // timeout abort
      issue(1'b0, 8'h03, 8'h00, 0, 1'b1, 1'b1, 8'h00, a);
      cmd_valid = 1'b0;
      repeat (TO + 1) @(negedge PCLK);
      chk("to_rsp_valid", rsp_valid, 1); chk("to_psel", PSEL, 0);
      chk("to_penable", PENABLE, 0); chk("to_cmd_ready", cmd_ready, 1);
      hang = 1'b0;
      @(negedge PCLK);
      chk("to_err_hold", rsp_err, 1);
      // back-to-back writes then reads
      for (int i = 0; i < 4; i++) issue(1'b1, 8'(i), vals[i], 0, 1'b0, 1'b1, 8'h00, acc[i]);
      for (int i = 1; i < 4; i++) chk("b2b_wr_spacing", acc[i] - acc[i-1], 3);
      for (int i = 0; i < 4; i++) issue(1'b0, 8'(i), 8'h00, 0, 1'b0, 1'b1, vals[i], acc[i]);
      for (int i = 1; i < 4; i++) chk("b2b_rd_spacing", acc[i] - acc[i-1], 3);
      cmd_valid = 1'b0;
      repeat (3) @(negedge PCLK);
      // command presented while busy is held off until the next IDLE cycle
      issue(1'b1, 8'h01, 8'h11, 2, 1'b0, 1'b1, 8'h00, a);
      issue(1'b0, 8'h05, 8'h00, 0, 1'b0, 1'b1, 8'h05, b);
      cmd_valid = 1'b0;
      chk("busy_accept_cycle", b - a, 5);
      repeat (3) @(negedge PCLK);
      // reset in the middle of a stalled ACCESS drops the transfer
      issue(1'b0, 8'h04, 8'h00, 0, 1'b1, 1'b0, 8'h00, a);
      cmd_valid = 1'b0;
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b0;
      @(negedge PCLK);
      chk_reset_outputs("midreset");
      hang = 1'b0;
      exp_paddr = '0; exp_pwrite = 1'b0; exp_pwdata = '0;
      PRESETn = 1'b1;
      @(negedge PCLK);
      chk("midreset_cmd_ready", cmd_ready, 1);
      write0_phases();
      repeat (10) @(negedge PCLK);
      chk("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
APB requester (initiator) that drives the PSEL/PENABLE/PWRITE/PADDR/PWDATA bus into the team's 8-bit APB register-file responder and samples PRDATA/PREADY. A simple CPU-side command/response port feeds it, one transfer at a time. It sequences the APB SETUP and ACCESS phases, inserts wait states while PREADY is low, and aborts with an error after a programmable wait-state timeout.

Parameters:
ADDR_W, 8, width of cmd_addr and PADDR
DATA_W, 8, width of the data buses
TIMEOUT, 16, maximum number of ACCESS cycles with PREADY low before abort; 0 disables the timeout
TO_W, 8, width of the wait counter; TIMEOUT must be less than 2^TO_W

Ports:
PCLK  input  1  clock; all logic is on the rising edge
PRESETn  input  1  synchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  requester can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  target address
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  DATA_W  read data (0 for writes and errors)
rsp_err  output  1  transfer aborted by timeout; valid with rsp_valid
busy  output  1  transfer in progress (state != IDLE)
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  ADDR_W  APB address
PWDATA  output  DATA_W  APB write data
PRDATA  input  DATA_W  APB read data
PREADY  input  1  APB ready / wait-state control

Behaviour:
- Clocking and reset: one clock, PCLK. Reset is synchronous and active-low on PRESETn.
- Reset (PRESETn=0 at a rising edge of PCLK):
  - State goes to IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, busy and the wait counter all go to 0.
  - cmd_ready is 1 on the first cycle after reset is released.
  - A reset during SETUP or ACCESS drops the transfer silently: no rsp_valid is produced.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - When cmd_valid=1 at an edge, capture cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- SETUP (exactly one cycle):
  - PSEL=1, PENABLE=0, cmd_ready=0.
  - Go to ACCESS unconditionally; PREADY is ignored.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PREADY is sampled at each rising edge.
  - If PREADY=1: complete. Next cycle PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=0, rsp_rdata=PRDATA for reads or 0 for writes. Return to IDLE.
  - If PREADY=0: increment the wait counter. If TIMEOUT!=0 and the counter reaches TIMEOUT, abort. Abort gives the same exit as completion, but with rsp_err=1 and rsp_rdata=0.
  - The wait counter clears when entering SETUP.
- Timing:
  - Minimum latency is 3 edges from command acceptance to rsp_valid: accept edge -> SETUP -> ACCESS -> rsp_valid.
  - Each wait state adds one cycle.
  - Peak throughput is one transfer per 3 cycles. cmd_ready is asserted in the same cycle as rsp_valid, so a new command can be accepted that cycle.
- Handshakes:
  - cmd_valid is ignored while cmd_ready=0. No command buffering.
  - rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata and rsp_err hold their value until the next response.
- Bus stability:
  - PADDR, PWRITE and PWDATA are constant from SETUP through the last ACCESS cycle.
  - After completion they keep their last values until the next command.
  - PWDATA is not updated for reads; it keeps its previous value.
- The wait counter saturates at 2^TO_W-1 when TIMEOUT=0, with no wrap.

Test Plan:
- Write, zero wait: after reset, cmd write addr 0x00 data 0xAA, PREADY=1 -> PSEL high for 2 cycles with PENABLE only on the 2nd; PADDR=0x00, PWDATA=0xAA, PWRITE=1; rsp_valid 3 cycles after acceptance, rsp_err=0, rsp_rdata=0.
- Read, wait states: cmd read addr 0x02, PREADY low for 2 ACCESS cycles then high with PRDATA=0xCC -> ACCESS lasts 3 cycles; rsp_valid at acceptance+5, rsp_rdata=0xCC; PADDR stable throughout.
- Timeout: TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0; PSEL/PENABLE low; cmd_ready=1 next cycle.
- Back-to-back: writes 0..3 with 0xAA, 0xBB, 0xCC, 0xDD, cmd_valid held high, PREADY=1 -> 4 responses spaced 3 cycles apart; read-back of each address returns the written value from the responder model.
- Busy rejection: assert cmd_valid (addr 0x05) during SETUP/ACCESS of a prior transfer -> not accepted; PADDR unchanged until the prior transfer completes; accepted in the next IDLE cycle.
- Reset mid-ACCESS: PRESETn=0 during ACCESS with PREADY=0 -> next edge all outputs 0, no rsp_valid; the next command after release behaves as in the zero-wait write case.
